// File: rtl/debug_dump_tx_pkg.sv
// Shared MIPS debug definitions: dump FSM states, dump sections and
// word/byte framing constants used by the debug dump transmitter.
package debug_dump_tx_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_IDX_W     = 2;
  localparam int unsigned WORD_PTR_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SEC_PC  = 2'd0,
    SEC_REG = 2'd1,
    SEC_MEM = 2'd2
  } section_t;

endpackage

// File: rtl/debug_dump_tx.sv
// Debug dump transmitter: on a halt pulse, streams the PC, the register file
// and the data memory to a UART transmitter, one word at a time, LSB first.
//
// Ports:
//   i_clock, i_reset      clock, synchronous active-low reset
//   i_start               halt pulse, starts a dump when idle
//   i_pc                  PC value reported first
//   o_reg_addr/i_reg_data register-file read port (data valid 1 cycle later)
//   o_mem_addr/i_mem_data data-memory read port (data valid 1 cycle later)
//   o_tx_byte/o_tx_signal byte and one-cycle transmit request to the UART
//   i_tx_done             UART byte-complete pulse
//   o_busy, o_done        dump in progress / one-cycle dump-complete pulse
module debug_dump_tx
  import debug_dump_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH_UART = 8,
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned NUM_MEM         = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  output logic [4:0]                 o_reg_addr,
  input  logic [DATA_WIDTH-1:0]      i_reg_data,
  output logic [4:0]                 o_mem_addr,
  input  logic [DATA_WIDTH-1:0]      i_mem_data,
  output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
  output logic                       o_tx_signal,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [WORD_PTR_W-1:0] LAST_REG  = WORD_PTR_W'(NUM_REGS - 1);
  localparam logic [WORD_PTR_W-1:0] LAST_MEM  = WORD_PTR_W'(NUM_MEM - 1);

  state_t                     state_q, state_d;
  section_t                   sec_q, sec_d;
  logic [WORD_PTR_W-1:0]      word_q, word_d;
  logic [BYTE_IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0]      shreg_q, shreg_d;
  logic [DATA_WIDTH_UART-1:0] tx_byte_q, tx_byte_d;
  logic                       tx_signal_q, tx_signal_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  // State and output registers
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      sec_q       <= SEC_PC;
      word_q      <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      tx_byte_q   <= '0;
      tx_signal_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      tx_byte_q   <= tx_byte_d;
      tx_signal_q <= tx_signal_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so they appear registered in that state.
  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    word_d      = word_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    tx_byte_d   = tx_byte_q;
    tx_signal_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_FETCH;
          busy_d  = 1'b1;
          sec_d   = SEC_PC;
          word_d  = '0;
          idx_d   = '0;
        end
      end

      // Address is already on the read ports; wait for the read data
      ST_FETCH: state_d = ST_LATCH;

      ST_LATCH: begin
        case (sec_q)
          SEC_PC:  shreg_d = i_pc;
          SEC_REG: shreg_d = i_reg_data;
          default: shreg_d = i_mem_data;
        endcase
        idx_d       = '0;
        state_d     = ST_SEND;
        tx_signal_d = 1'b1;
        tx_byte_d   = shreg_d[DATA_WIDTH_UART-1:0];
      end

      // Request cycle: a done pulse here belongs to nothing and is ignored
      ST_SEND: state_d = ST_WAIT;

      ST_WAIT: begin
        if (i_tx_done) begin
          if (idx_q != LAST_BYTE) begin
            shreg_d     = shreg_q >> DATA_WIDTH_UART;
            idx_d       = idx_q + 1'b1;
            state_d     = ST_SEND;
            tx_signal_d = 1'b1;
            tx_byte_d   = shreg_d[DATA_WIDTH_UART-1:0];
          end else begin
            state_d = ST_FETCH;
            case (sec_q)
              SEC_PC: begin
                sec_d  = SEC_REG;
                word_d = '0;
              end
              SEC_REG: begin
                if (word_q == LAST_REG) begin
                  sec_d  = SEC_MEM;
                  word_d = '0;
                end else begin
                  word_d = word_q + 1'b1;
                end
              end
              default: begin
                if (word_q == LAST_MEM) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                end else begin
                  word_d = word_q + 1'b1;
                end
              end
            endcase
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Both read ports follow the word pointer; only the active section's data is used
  assign o_reg_addr  = word_q;
  assign o_mem_addr  = word_q;
  assign o_tx_byte   = tx_byte_q;
  assign o_tx_signal = tx_signal_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_debug_dump_tx.sv
// Bench for debug_dump_tx: scoreboard of expected bytes built from a
// word-list model, UART ack responder, registered regfile/memory models.
module tb_debug_dump_tx;

  localparam int unsigned DW     = 32;
  localparam int unsigned UW     = 8;
  localparam int unsigned NR     = 32;
  localparam int unsigned NM     = 32;
  localparam int unsigned NWORDS = 1 + NR + NM;
  localparam int unsigned NBYTES = NWORDS * 4;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [DW-1:0] i_pc;
  logic [4:0]    o_reg_addr;
  logic [DW-1:0] i_reg_data;
  logic [4:0]    o_mem_addr;
  logic [DW-1:0] i_mem_data;
  logic [UW-1:0] o_tx_byte;
  logic          o_tx_signal;
  logic          i_tx_done;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  debug_dump_tx #(
    .DATA_WIDTH(DW), .DATA_WIDTH_UART(UW), .NUM_REGS(NR), .NUM_MEM(NM)
  ) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_pc       (i_pc),
    .o_reg_addr (o_reg_addr),
    .i_reg_data (i_reg_data),
    .o_mem_addr (o_mem_addr),
    .i_mem_data (i_mem_data),
    .o_tx_byte  (o_tx_byte),
    .o_tx_signal(o_tx_signal),
    .i_tx_done  (i_tx_done),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  // Register file and data memory with one-cycle read latency
  logic [DW-1:0] regs [NR];
  logic [DW-1:0] mems [NM];
  always @(posedge clk) begin
    i_reg_data <= regs[o_reg_addr];
    i_mem_data <= mems[o_mem_addr];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q [$];
  logic [7:0] cap [0:4095];
  int req_count  = 0;
  int done_count = 0;

  int ack_en       = 1;
  int ack_same     = 0;
  int ack_delay    = 10;
  int spur_seq     = 0;
  int last_ack_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every transmit request; check done timing
  always @(negedge clk) begin
    if (o_tx_signal) begin
      check("byte expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check($sformatf("byte %0d", req_count), 32'(o_tx_byte), 32'(exp_q.pop_front()));
      if (req_count < 4096) cap[req_count] = o_tx_byte;
      req_count++;
    end
    if (o_done) begin
      done_count++;
      check("done one cycle after last ack", 32'(cyc), 32'(last_ack_cyc + 1));
      check("busy low with done", 32'(o_busy), 32'd0);
    end
  end

  // UART responder: ack ack_delay cycles after each request, plus injected pulses
  initial begin : acker
    int cnt;
    int spur_seen;
    logic td;
    cnt = 0;
    spur_seen = 0;
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      td = 1'b0;
      if (o_tx_signal) begin
        if (ack_same != 0) td = 1'b1;
        if (ack_en != 0) cnt = ack_delay;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          td = 1'b1;
          last_ack_cyc = cyc;
        end
      end
      if (spur_seen != spur_seq) begin
        td = 1'b1;
        spur_seen = spur_seq;
      end
      i_tx_done = td;
    end
  end

  // Reference model: the word list in dump order, each word split LSB first
  task automatic push_expected(input logic [31:0] pc);
    logic [31:0] w;
    for (int i = 0; i < int'(NWORDS); i++) begin
      if (i == 0) w = pc;
      else if (i <= int'(NR)) w = regs[i-1];
      else w = mems[i-1-int'(NR)];
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (8 * b)));
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk) i_reset = 1'b0;
    @(negedge clk) i_reset = 1'b1;
  endtask

  // Full dump with optional mid-stream restart pulse and spurious acks
  task automatic run_dump(input string name, input logic [31:0] pc, input int restart_at,
                          input bit spur, output int base);
    int d0;
    int n;
    bit fired;
    base = req_count;
    d0 = done_count;
    i_pc = pc;
    push_expected(pc);
    if (spur) begin
      spur_seq++;
      repeat (3) @(negedge clk);
    end
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    if (spur) spur_seq++;
    check({name, " busy after start"}, 32'(o_busy), 32'd1);
    n = 0;
    fired = 1'b0;
    while (done_count == d0 && n < 8000) begin
      @(negedge clk);
      n++;
      i_start = 1'b0;
      if (restart_at >= 0 && !fired && (req_count - base) >= restart_at) begin
        i_start = 1'b1;
        fired = 1'b1;
      end
    end
    i_start = 1'b0;
    check({name, " done within budget"}, 32'(done_count != d0), 32'd1);
    repeat (20) @(negedge clk);
    check({name, " byte count"}, 32'(req_count - base), 32'(NBYTES));
    check({name, " done count"}, 32'(done_count - d0), 32'd1);
    check({name, " scoreboard drained"}, 32'(exp_q.size()), 32'd0);
    check({name, " busy low after"}, 32'(o_busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int n;
    int r0;
    bit stable;
    bit busy_ok;
    logic [31:0] pc;

    i_reset = 1'b0;
    i_start = 1'b0;
    i_pc    = '0;
    for (int i = 0; i < int'(NR); i++) regs[i] = 32'(i);
    for (int i = 0; i < int'(NM); i++) mems[i] = 32'(32'hA0 + i);

    repeat (3) @(negedge clk);
    check("reset tx_signal", 32'(o_tx_signal), 32'd0);
    check("reset tx_byte",   32'(o_tx_byte),   32'd0);
    check("reset busy",      32'(o_busy),      32'd0);
    check("reset done",      32'(o_done),      32'd0);
    check("reset reg_addr",  32'(o_reg_addr),  32'd0);
    check("reset mem_addr",  32'(o_mem_addr),  32'd0);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);

    // Directed dump, ack 10 cycles after each request
    ack_delay = 10;
    run_dump("basic", 32'h0000_0034, -1, 1'b0, base);
    check("basic byte 0",   32'(cap[base+0]),   32'h34);
    check("basic byte 4",   32'(cap[base+4]),   32'h00);
    check("basic byte 8",   32'(cap[base+8]),   32'h01);
    check("basic byte 132", 32'(cap[base+132]), 32'hA0);

    // Stalled UART: one request, byte held, busy held
    ack_en = 0;
    base = req_count;
    push_expected(32'h34);
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    n = 0;
    while (req_count == base && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall first request seen", 32'(req_count - base), 32'd1);
    stable = 1'b1;
    busy_ok = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (o_tx_byte !== 8'h34) stable = 1'b0;
      if (o_busy !== 1'b1) busy_ok = 1'b0;
    end
    check("stall request count", 32'(req_count - base), 32'd1);
    check("stall byte stable",   32'(stable),  32'd1);
    check("stall busy held",     32'(busy_ok), 32'd1);
    reset_pulse();
    exp_q.delete();
    ack_en = 1;
    repeat (5) @(negedge clk);

    // Start pulse while busy is ignored
    run_dump("restart", 32'h0000_0034, 50, 1'b0, base);

    // Reset mid-dump
    base = req_count;
    push_expected(32'h34);
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    n = 0;
    while ((req_count - base) < 100 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reach byte 100", 32'(req_count - base >= 100), 32'd1);
    i_reset = 1'b0;
    @(posedge clk);
    #1;
    check("midreset tx_signal", 32'(o_tx_signal), 32'd0);
    check("midreset tx_byte",   32'(o_tx_byte),   32'd0);
    check("midreset busy",      32'(o_busy),      32'd0);
    check("midreset done",      32'(o_done),      32'd0);
    check("midreset reg_addr",  32'(o_reg_addr),  32'd0);
    check("midreset mem_addr",  32'(o_mem_addr),  32'd0);
    @(negedge clk) i_reset = 1'b1;
    exp_q.delete();
    r0 = req_count;
    repeat (40) @(negedge clk);
    check("no requests after reset", 32'(req_count - r0), 32'd0);
    run_dump("after reset", 32'h0000_0034, -1, 1'b0, base);
    check("after reset byte 0", 32'(cap[base]), 32'h34);

    // Spurious acks in IDLE and FETCH
    run_dump("spurious", 32'h0000_0034, -1, 1'b1, base);

    // Boundary words of each section
    for (int i = 0; i < int'(NR); i++) regs[i] = $urandom;
    for (int i = 0; i < int'(NM); i++) mems[i] = $urandom;
    regs[NR-1] = 32'hDEAD_BEEF;
    mems[NM-1] = 32'h1234_5678;
    pc = $urandom;
    ack_delay = $urandom_range(1, 6);
    run_dump("boundary", pc, -1, 1'b0, base);
    check("reg31 byte 128", 32'(cap[base+128]), 32'hEF);
    check("reg31 byte 129", 32'(cap[base+129]), 32'hBE);
    check("reg31 byte 130", 32'(cap[base+130]), 32'hAD);
    check("reg31 byte 131", 32'(cap[base+131]), 32'hDE);
    check("mem31 byte 256", 32'(cap[base+256]), 32'h78);
    check("mem31 byte 257", 32'(cap[base+257]), 32'h56);
    check("mem31 byte 258", 32'(cap[base+258]), 32'h34);
    check("mem31 byte 259", 32'(cap[base+259]), 32'h12);

    // Random data, random ack latency, ack pulses coincident with requests
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < int'(NR); i++) regs[i] = $urandom;
      for (int i = 0; i < int'(NM); i++) mems[i] = $urandom;
      ack_delay = $urandom_range(1, 12);
      ack_same  = 1;
      run_dump($sformatf("random%0d", t), $urandom, -1, 1'b0, base);
    end
    ack_same = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
